// File: rtl/psram_pkg.sv
// Types and constants shared by the PSRAM arbiter, game_loader and the PSRAM controller.
package psram_pkg;

  localparam int PSRAM_ADDR_W = 22;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_RD = 2'd1,
    WAIT_RD  = 2'd2,
    ISSUE_WR = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                    write;
    logic [PSRAM_ADDR_W-1:0] addr;
    logic [7:0]              wdata;
  } psram_cmd_t;

endpackage

// File: rtl/psram_req_slot.sv
// One-entry request holding register: fill when empty, free releases it.
module psram_req_slot #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 8,
  localparam int W = ADDR_W + DATA_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         fill,
  input  logic [W-1:0] fill_payload,
  input  logic         free,
  output logic         busy,
  output logic [W-1:0] payload
);

  // free only ever arrives while occupied, so it wins over a fill attempt
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      payload <= '0;
    end else if (free) begin
      busy <= 1'b0;
    end else if (fill && !busy) begin
      busy    <= 1'b1;
      payload <= fill_payload;
    end
  end

endmodule

// File: rtl/psram_port_arbiter.sv
// Shares the PSRAM command port between loader writes and console reads,
// console first with a starvation limit so loader writes still progress.
module psram_port_arbiter
  import psram_pkg::*;
#(
  parameter int ADDR_W       = PSRAM_ADDR_W,
  parameter int STARVE_LIMIT = 4,
  parameter int RD_TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_busy,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_busy,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              rd_overrun,
  output logic              rd_timeout,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_write,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [7:0]        mem_cmd_wdata,
  input  logic              mem_rd_valid,
  input  logic [7:0]        mem_rd_data,
  output arb_state_t        dbg_state
);

  // Command handshake: a command transfers on the rising edge where
  // mem_cmd_valid & mem_cmd_ready are both 1; while valid is high and ready
  // low, write/addr/wdata are held unchanged.

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TO_LIM     = 8'(RD_TIMEOUT);

  arb_state_t          state;
  logic [3:0]          starve_cnt;
  logic [7:0]          to_cnt;
  logic [7:0]          to_next;
  logic                wr_fill;
  logic                rd_fill;
  logic                wr_free;
  logic                rd_free;
  logic                read_wins;
  logic [ADDR_W+7:0]   wr_payload;
  logic [ADDR_W-1:0]   rd_slot_addr;

  assign dbg_state = state;
  assign wr_fill   = wr_req && !wr_busy;
  assign rd_fill   = rd_req && !rd_busy;
  assign to_next   = to_cnt + 8'd1;

  // An incoming read strobe counts as pending so a console that re-requests
  // as soon as rd_busy drops keeps its priority; IDLE then waits one cycle
  // for the slot to fill instead of handing the port to the loader.
  always_comb begin
    read_wins = (rd_busy || rd_fill) && (!wr_busy || (starve_cnt < STARVE_MAX));
    wr_free   = (state == ISSUE_WR) && mem_cmd_ready;
    rd_free   = (state == WAIT_RD) && (mem_rd_valid || (to_next == TO_LIM));
  end

  psram_req_slot #(.ADDR_W(ADDR_W), .DATA_W(8)) u_wr_slot (
    .clk          (clk),
    .reset_n      (reset_n),
    .fill         (wr_fill),
    .fill_payload ({wr_addr, wr_data}),
    .free         (wr_free),
    .busy         (wr_busy),
    .payload      (wr_payload)
  );

  psram_req_slot #(.ADDR_W(ADDR_W), .DATA_W(0)) u_rd_slot (
    .clk          (clk),
    .reset_n      (reset_n),
    .fill         (rd_fill),
    .fill_payload (rd_addr),
    .free         (rd_free),
    .busy         (rd_busy),
    .payload      (rd_slot_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      starve_cnt    <= 4'd0;
      to_cnt        <= 8'd0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_write <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_cmd_wdata <= 8'd0;
      rd_data       <= 8'd0;
      rd_valid      <= 1'b0;
      rd_overrun    <= 1'b0;
      rd_timeout    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_req && rd_busy) rd_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (read_wins) begin
            if (rd_busy) begin
              state         <= ISSUE_RD;
              mem_cmd_valid <= 1'b1;
              mem_cmd_write <= 1'b0;
              mem_cmd_addr  <= rd_slot_addr;
            end
          end else if (wr_busy) begin
            state         <= ISSUE_WR;
            mem_cmd_valid <= 1'b1;
            mem_cmd_write <= 1'b1;
            mem_cmd_addr  <= wr_payload[ADDR_W+7:8];
            mem_cmd_wdata <= wr_payload[7:0];
          end
        end
        ISSUE_RD: begin
          if (mem_cmd_ready) begin
            state         <= WAIT_RD;
            mem_cmd_valid <= 1'b0;
            to_cnt        <= 8'd0;
            if (wr_busy && (starve_cnt != 4'hF)) starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ISSUE_WR: begin
          if (mem_cmd_ready) begin
            state         <= IDLE;
            mem_cmd_valid <= 1'b0;
            starve_cnt    <= 4'd0;
          end
        end
        WAIT_RD: begin
          if (mem_rd_valid) begin
            rd_data  <= mem_rd_data;
            rd_valid <= 1'b1;
            state    <= IDLE;
          end else if (to_next == TO_LIM) begin
            rd_timeout <= 1'b1;
            state      <= IDLE;
          end else begin
            to_cnt <= to_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Directed bench for psram_port_arbiter: one task per scenario, inline checks.
module tb_psram_port_arbiter;
  import psram_pkg::*;

  localparam int ADDR_W = PSRAM_ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_busy;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_busy;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              rd_overrun;
  logic              rd_timeout;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_write;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [7:0]        mem_cmd_wdata;
  logic              mem_rd_valid;
  logic [7:0]        mem_rd_data;
  arb_state_t        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected and observed command streams as {write, addr}
  logic [ADDR_W:0] exp_q[$];
  logic [ADDR_W:0] obs_q[$];

  // Memory-side read responder, enabled only for the starvation scenario
  bit         auto_resp = 1'b0;
  int         resp_lat  = 2;
  int         resp_cnt  = 0;
  logic [7:0] resp_data = 8'h80;

  psram_port_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_busy       (wr_busy),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_busy       (rd_busy),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_overrun    (rd_overrun),
    .rd_timeout    (rd_timeout),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_write (mem_cmd_write),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_wdata (mem_cmd_wdata),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- monitors ----------------
  initial forever begin
    @(posedge clk);
    if (reset_n === 1'b1 && mem_cmd_valid === 1'b1 && mem_cmd_ready === 1'b1)
      obs_q.push_back({mem_cmd_write, mem_cmd_addr});
  end

  initial forever begin
    @(posedge clk);
    if (auto_resp && mem_cmd_valid && mem_cmd_ready && !mem_cmd_write) resp_cnt = resp_lat;
    @(negedge clk);
    if (auto_resp) begin
      mem_rd_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = resp_data;
          resp_data++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [ADDR_W+23:0] outs;
    reset_n = 1'b0;
    wr_req = 0; wr_addr = '0; wr_data = 0;
    rd_req = 0; rd_addr = '0;
    mem_cmd_ready = 0; mem_rd_valid = 0; mem_rd_data = 0;
    repeat (3) tick();
    outs = {wr_busy, rd_busy, rd_data, rd_valid, rd_overrun, rd_timeout,
            mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata};
    if (outs !== '0) begin
      $display("FAIL reset_outputs: got %h, expected 0", outs); n_fail++;
    end
    n_tests++;
    if (dbg_state !== IDLE) begin
      $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE); n_fail++;
    end
    n_tests++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    mem_cmd_ready = 1'b1;
    obs_q.delete();
    wr_req = 1; wr_addr = 22'h004000; wr_data = 8'hA5;
    tick();
    wr_req = 0;
    if ({wr_busy, mem_cmd_valid} !== 2'b10) begin
      $display("FAIL wr_n1: got busy,valid=%b, expected 10", {wr_busy, mem_cmd_valid}); n_fail++;
    end
    n_tests++;
    tick();
    if ({wr_busy, mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata} !== {3'b111, 22'h004000, 8'hA5}) begin
      $display("FAIL wr_cmd: got busy=%b valid=%b write=%b addr=%h wdata=%h, expected 1 1 1 004000 a5",
               wr_busy, mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata); n_fail++;
    end
    n_tests++;
    tick();
    if ({wr_busy, mem_cmd_valid} !== 2'b00) begin
      $display("FAIL wr_n3: got busy,valid=%b, expected 00", {wr_busy, mem_cmd_valid}); n_fail++;
    end
    n_tests++;
    tick();
    if (obs_q.size() != 1) begin
      $display("FAIL wr_count: got %0d commands, expected 1", obs_q.size()); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_read_latency();
    mem_cmd_ready = 1'b1;
    rd_req = 1; rd_addr = 22'h004123;
    tick();
    rd_req = 0;
    tick();
    if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr} !== {2'b10, 22'h004123}) begin
      $display("FAIL rd_cmd: got valid=%b write=%b addr=%h, expected 1 0 004123",
               mem_cmd_valid, mem_cmd_write, mem_cmd_addr); n_fail++;
    end
    n_tests++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if ({rd_valid, rd_busy} !== 2'b01) begin
        $display("FAIL rd_wait%0d: got valid,busy=%b, expected 01", k, {rd_valid, rd_busy}); n_fail++;
      end
      n_tests++;
    end
    mem_rd_valid = 1; mem_rd_data = 8'h5C;
    tick();
    mem_rd_valid = 0;
    if ({rd_valid, rd_busy, rd_data} !== {2'b10, 8'h5C}) begin
      $display("FAIL rd_data: got valid=%b busy=%b data=%h, expected 1 0 5c", rd_valid, rd_busy, rd_data); n_fail++;
    end
    n_tests++;
    tick();
    if (rd_valid !== 1'b0) begin
      $display("FAIL rd_pulse: got rd_valid=%b, expected 0", rd_valid); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_starvation();
    int rd_idx;
    int cyc;
    logic [ADDR_W:0] exp_v;
    logic [ADDR_W:0] got_v;
    mem_cmd_ready = 1'b1;
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 22'(32'h200 + i)});
    exp_q.push_back({1'b1, 22'h000100});
    exp_q.push_back({1'b0, 22'h000204});
    resp_lat = 2;
    auto_resp = 1'b1;
    wr_req = 1; wr_addr = 22'h000100; wr_data = 8'h11;
    rd_req = 1; rd_addr = 22'h000200;
    rd_idx = 1;
    cyc = 0;
    while (obs_q.size() < 6 && cyc < 400) begin
      tick();
      cyc++;
      wr_req = 0;
      rd_req = 0;
      if (!rd_busy && rd_idx < 5) begin
        rd_req  = 1;
        rd_addr = 22'(32'h200 + rd_idx);
        rd_idx++;
      end
    end
    tick();
    rd_req = 0;
    repeat (10) tick();
    auto_resp = 1'b0;
    mem_rd_valid = 1'b0;
    if (cyc >= 400) begin
      $display("FAIL starve_timeout: got %0d commands, expected 6", obs_q.size()); n_fail++;
    end
    n_tests++;
    for (int i = 0; i < 6; i++) begin
      exp_v = exp_q.pop_front();
      got_v = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      if (got_v !== exp_v) begin
        $display("FAIL starve_cmd%0d: got write,addr=%h, expected %h", i, got_v, exp_v); n_fail++;
      end
      n_tests++;
    end
    if ({wr_busy, rd_busy} !== 2'b00) begin
      $display("FAIL starve_drain: got wr,rd busy=%b, expected 00", {wr_busy, rd_busy}); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_backpressure();
    mem_cmd_ready = 1'b0;
    wr_req = 1; wr_addr = 22'h0ABCDE; wr_data = 8'h3C;
    rd_req = 1; rd_addr = 22'h012345;
    tick();
    wr_req = 0; rd_req = 0;
    if ({wr_busy, rd_busy, mem_cmd_valid} !== 3'b110) begin
      $display("FAIL bp_capture: got wr,rd,valid=%b, expected 110", {wr_busy, rd_busy, mem_cmd_valid}); n_fail++;
    end
    n_tests++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr} !== {2'b10, 22'h012345}) begin
        $display("FAIL bp_hold%0d: got valid=%b write=%b addr=%h, expected 1 0 012345",
                 i, mem_cmd_valid, mem_cmd_write, mem_cmd_addr); n_fail++;
      end
      n_tests++;
      if (i == 0 || i == 4) begin
        if (rd_overrun !== (i == 4)) begin
          $display("FAIL bp_overrun%0d: got %b, expected %b", i, rd_overrun, (i == 4)); n_fail++;
        end
        n_tests++;
      end
      rd_req = (i == 2);
      wr_req = (i == 2);
      rd_addr = 22'h3FFFFF;
      wr_addr = 22'h000001;
      wr_data = 8'hC3;
    end
    tick();
    rd_req = 0; wr_req = 0;
    mem_cmd_ready = 1'b1;
    tick();
    if (dbg_state !== WAIT_RD) begin
      $display("FAIL bp_wait_state: got %0d, expected %0d", dbg_state, WAIT_RD); n_fail++;
    end
    n_tests++;
    mem_rd_valid = 1; mem_rd_data = 8'h77;
    tick();
    mem_rd_valid = 0;
    if ({rd_valid, rd_data} !== {1'b1, 8'h77}) begin
      $display("FAIL bp_rd_data: got valid=%b data=%h, expected 1 77", rd_valid, rd_data); n_fail++;
    end
    n_tests++;
    tick();
    if ({mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata} !== {2'b11, 22'h0ABCDE, 8'h3C}) begin
      $display("FAIL bp_wr_cmd: got valid=%b write=%b addr=%h wdata=%h, expected 1 1 0abcde 3c",
               mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata); n_fail++;
    end
    n_tests++;
    tick();
    if ({wr_busy, mem_cmd_valid} !== 2'b00) begin
      $display("FAIL bp_wr_done: got busy,valid=%b, expected 00", {wr_busy, mem_cmd_valid}); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_timeout();
    logic saw_valid;
    mem_cmd_ready = 1'b1;
    rd_req = 1; rd_addr = 22'h000777;
    tick();
    rd_req = 0;
    tick();
    if ({mem_cmd_valid, mem_cmd_addr} !== {1'b1, 22'h000777}) begin
      $display("FAIL to_cmd: got valid=%b addr=%h, expected 1 000777", mem_cmd_valid, mem_cmd_addr); n_fail++;
    end
    n_tests++;
    saw_valid = 1'b0;
    for (int k = 0; k < 258; k++) begin
      tick();
      saw_valid = saw_valid | rd_valid;
      if (k == 253) begin
        if ({rd_timeout, rd_busy} !== 2'b01) begin
          $display("FAIL to_early: got timeout,busy=%b, expected 01", {rd_timeout, rd_busy}); n_fail++;
        end
        n_tests++;
      end
    end
    if ({rd_timeout, rd_busy, saw_valid} !== 3'b100) begin
      $display("FAIL to_fire: got timeout,busy,saw_valid=%b, expected 100", {rd_timeout, rd_busy, saw_valid}); n_fail++;
    end
    n_tests++;
    mem_rd_valid = 1; mem_rd_data = 8'hEE;
    tick();
    mem_rd_valid = 0;
    tick();
    if ({rd_valid, rd_data, rd_timeout} !== {1'b0, 8'h77, 1'b1}) begin
      $display("FAIL to_late: got valid=%b data=%h timeout=%b, expected 0 77 1", rd_valid, rd_data, rd_timeout); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_reset_mid_read();
    logic [ADDR_W+23:0] outs;
    mem_cmd_ready = 1'b1;
    rd_req = 1; rd_addr = 22'h000999;
    tick();
    rd_req = 0;
    repeat (2) tick();
    if (dbg_state !== WAIT_RD) begin
      $display("FAIL rst_pre_state: got %0d, expected %0d", dbg_state, WAIT_RD); n_fail++;
    end
    n_tests++;
    reset_n = 1'b0;
    tick();
    outs = {wr_busy, rd_busy, rd_data, rd_valid, rd_overrun, rd_timeout,
            mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_wdata};
    if (outs !== '0 || dbg_state !== IDLE) begin
      $display("FAIL rst_mid_outputs: got %h state %0d, expected 0 state 0", outs, dbg_state); n_fail++;
    end
    n_tests++;
    reset_n = 1'b1;
    mem_rd_valid = 1; mem_rd_data = 8'h42;
    tick();
    mem_rd_valid = 0;
    if ({rd_valid, rd_busy, rd_data} !== 10'd0) begin
      $display("FAIL rst_stale: got valid=%b busy=%b data=%h, expected 0 0 00", rd_valid, rd_busy, rd_data); n_fail++;
    end
    n_tests++;
    tick();
    if ({rd_valid, mem_cmd_valid} !== 2'b00) begin
      $display("FAIL rst_quiet: got rd_valid,cmd_valid=%b, expected 00", {rd_valid, mem_cmd_valid}); n_fail++;
    end
    n_tests++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_read_latency();
    test_starvation();
    test_backpressure();
    test_timeout();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
